// File: rtl/decode_general_register_pipe.sv
// Pipelined multi-port general-register decoder: reg field + w field + operand size to one-hot
// 8/16/32-bit selects, registered behind a valid/ready handshake with a 2-entry skid buffer.
module decode_general_register_pipe #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               bit_width,
  input  logic [3*NUM_PORTS-1:0]   register,
  input  logic [NUM_PORTS-1:0]     w_in_instruction,
  input  logic [NUM_PORTS-1:0]     w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*NUM_PORTS-1:0]   sel_08bit,
  output logic [8*NUM_PORTS-1:0]   sel_16bit,
  output logic [8*NUM_PORTS-1:0]   sel_32bit,
  output logic [NUM_PORTS-1:0]     illegal,
  output logic [COUNT_WIDTH-1:0]   illegal_count
);

  // Occupancy encoding: bit 0 = OUT valid, bit 1 = SKID valid.
  localparam logic [1:0] StEmpty = 2'b00;
  localparam logic [1:0] StOne   = 2'b01;
  localparam logic [1:0] StFull  = 2'b11;

  logic [1:0] state_q, state_d;

  logic [8*NUM_PORTS-1:0] dec_sel08, dec_sel16, dec_sel32;
  logic [NUM_PORTS-1:0]   dec_illegal;
  logic                   bw_legal;

  logic [8*NUM_PORTS-1:0] out_sel08_q, out_sel16_q, out_sel32_q;
  logic [NUM_PORTS-1:0]   out_illegal_q;
  logic [8*NUM_PORTS-1:0] skid_sel08_q, skid_sel16_q, skid_sel32_q;
  logic [NUM_PORTS-1:0]   skid_illegal_q;
  logic [COUNT_WIDTH-1:0] illegal_count_q;

  logic accept, drain;
  logic load_out, load_skid, out_from_skid;

  assign bw_legal = (bit_width == 2'b01) || (bit_width == 2'b10);

  always_comb begin
    dec_sel08   = '0;
    dec_sel16   = '0;
    dec_sel32   = '0;
    dec_illegal = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!bw_legal) begin
        dec_illegal[p] = 1'b1;
      end else if (w_in_instruction[p] && !w[p]) begin
        dec_sel08[8*p +: 8] = 8'b1 << register[3*p +: 3];
      end else if (bit_width == 2'b01) begin
        dec_sel16[8*p +: 8] = 8'b1 << register[3*p +: 3];
      end else begin
        dec_sel32[8*p +: 8] = 8'b1 << register[3*p +: 3];
      end
    end
  end

  // in_ready looks only at registered occupancy and reset, never at out_ready.
  assign in_ready  = !state_q[1] && !reset;
  assign out_valid = state_q[0];
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d  = StOne;
          load_out = 1'b1;
        end
      end
      StOne: begin
        if (accept && drain) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_d   = StFull;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (drain) begin
          state_d       = StOne;
          out_from_skid = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StEmpty;
      out_sel08_q     <= '0;
      out_sel16_q     <= '0;
      out_sel32_q     <= '0;
      out_illegal_q   <= '0;
      skid_sel08_q    <= '0;
      skid_sel16_q    <= '0;
      skid_sel32_q    <= '0;
      skid_illegal_q  <= '0;
      illegal_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_out) begin
        out_sel08_q   <= dec_sel08;
        out_sel16_q   <= dec_sel16;
        out_sel32_q   <= dec_sel32;
        out_illegal_q <= dec_illegal;
      end else if (out_from_skid) begin
        out_sel08_q   <= skid_sel08_q;
        out_sel16_q   <= skid_sel16_q;
        out_sel32_q   <= skid_sel32_q;
        out_illegal_q <= skid_illegal_q;
      end
      if (load_skid) begin
        skid_sel08_q   <= dec_sel08;
        skid_sel16_q   <= dec_sel16;
        skid_sel32_q   <= dec_sel32;
        skid_illegal_q <= dec_illegal;
      end
      if (accept && !bw_legal && (illegal_count_q != {COUNT_WIDTH{1'b1}})) begin
        illegal_count_q <= illegal_count_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign sel_08bit     = out_sel08_q;
  assign sel_16bit     = out_sel16_q;
  assign sel_32bit     = out_sel32_q;
  assign illegal       = out_illegal_q;
  assign illegal_count = illegal_count_q;

endmodule

// File: doc/decode_general_register_pipe.md
# decode_general_register_pipe

Pipelined, multi-port successor of the combinational general-register decoder: for each of `NUM_PORTS` operand slots it turns a 3-bit reg field, the w-field presence/value and the current operand size into one-hot 8/16/32-bit register selects. It sits between the instruction-field extractor and the register-file read stage. It registers its results behind a valid/ready handshake with a 2-entry skid buffer for full throughput. It also flags and counts illegal operand-size encodings.

## Interface
- `NUM_PORTS`, 2, number of independent reg-field decode slots per transfer (1..4)
- `COUNT_WIDTH`, 8, width of the saturating illegal-transfer counter
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream transfer valid
- `in_ready`  out  1  block can accept a transfer
- `bit_width`  in  2  one-hot operand size shared by all ports: 2'b01 = 16-bit, 2'b10 = 32-bit; other values are illegal
- `register`  in  3*NUM_PORTS  reg field per port; port p uses bits [3p+2:3p]
- `w_in_instruction`  in  NUM_PORTS  per port, 1 = instruction carries a w field
- `w`  in  NUM_PORTS  per port w value; ignored when the matching `w_in_instruction` = 0
- `out_valid`  out  1  decoded transfer valid
- `out_ready`  in  1  downstream accepts
- `sel_08bit`  out  8*NUM_PORTS  one-hot; bit i of port p = reg index i (AL,CL,DL,BL,AH,CH,DH,BH for i = 0..7)
- `sel_16bit`  out  8*NUM_PORTS  one-hot (AX,CX,DX,BX,SP,BP,SI,DI)
- `sel_32bit`  out  8*NUM_PORTS  one-hot (EAX,ECX,EDX,EBX,ESP,EBP,ESI,EDI)
- `illegal`  out  NUM_PORTS  per port, `bit_width` not one-hot for that transfer
- `illegal_count`  out  COUNT_WIDTH  number of accepted transfers with any `illegal` bit set; saturates

## Operation
- Decode per port (pure function of the captured inputs):
  - `w_in_instruction` = 0: `bit_width` 01 selects 16-bit, 10 selects 32-bit.
  - `w_in_instruction` = 1, `w` = 0: 8-bit, regardless of `bit_width`, provided `bit_width` is legal.
  - `w_in_instruction` = 1, `w` = 1: size taken from `bit_width`, as in the first case.
  - Exactly one bit is set in the selected size vector; the other two vectors are 0.
  - Illegal `bit_width` (00 or 11): all three vectors for every port are 0 and all `illegal` bits are 1. The transfer still completes normally.
- Storage: output register (OUT) plus one skid entry (SKID). Decoding happens before capture, so both stages hold decoded data.
- States, by occupancy:
  - EMPTY: OUT invalid, SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: OUT valid, SKID valid.
- `in_ready` = !SKID valid && !reset.
- Accept = `in_valid` && `in_ready`. Drain = `out_valid` && `out_ready`.
- Transitions:
  - EMPTY + accept → ONE; the data goes to OUT.
  - ONE + accept + drain → ONE; OUT is replaced.
  - ONE + accept, no drain → FULL; the data goes to SKID.
  - ONE + drain, no accept → EMPTY.
  - FULL + drain → ONE; SKID moves to OUT. No accept is possible because `in_ready` = 0.
- Ordering is strictly FIFO. No transfer is dropped or duplicated.
- `illegal_count` increments by 1 on each accept whose decode is illegal. It holds at 2^COUNT_WIDTH-1.
- Reset (any cycle, including mid-stream): both entries are invalidated and in-flight data is discarded.
  - Reset values: `out_valid` = 0, `in_ready` = 0 while `reset` is high, all `sel_*` = 0, `illegal` = 0, `illegal_count` = 0.

## Timing
- Latency: a transfer accepted at edge N is visible on the outputs after edge N (`out_valid` = 1 in cycle N+1).
- Throughput: one transfer per cycle while `out_ready` = 1.
- Stall behaviour: while `out_valid` && !`out_ready`, all outputs hold stable. `in_ready` falls the cycle after SKID fills.
- `in_ready` depends only on registered state and `reset`, with no combinational path from `out_ready`.
- All outputs except `in_ready` come directly from flops.
- The first accept is possible in the cycle after `reset` deasserts.

## Test plan
- Reset, then one transfer with `bit_width` = 10, port0 `register` = 3, `w_in_instruction` = 0 → next cycle `out_valid` = 1 and port0 `sel_32bit` = 8'h08 (EBX); `sel_08bit` and `sel_16bit` = 0.
- `w_in_instruction` = 1, `w` = 0, `register` = 4, `bit_width` = 01 → `sel_08bit` = 8'h10 (AH). Same fields with `w` = 1 → `sel_16bit` = 8'h10 (SP).
- `bit_width` = 11 on 3 transfers → `illegal` all 1s and all `sel_*` 0 on each. `illegal_count` = 3. With `COUNT_WIDTH` = 2, a 4th illegal transfer leaves the count at 3.
- Hold `out_ready` = 0, push A, B, C back to back → A and B are accepted and C stalls (`in_ready` = 0). Release → outputs A, B, C in order, one per cycle.
- Stream 16 transfers with random `register` values and `out_ready` = 1 → `in_ready` stays 1 throughout and the output sequence matches the reference model, lagging by 1 cycle.
- Assert `reset` while in FULL with `out_ready` = 0 → next cycle `out_valid` = 0, `sel_*` = 0, `illegal_count` = 0; the old data never appears on the outputs.
